// File: rtl/rename_stage_pkg.sv
// Shared widths and uop types for the register-rename stage.
// Logical register fields travel in physical-width slots so one uop_t serves both sides.
package rename_stage_pkg;

    localparam int DEF_LOG_RF_DEPTH = 32;
    localparam int DEF_PHY_RF_DEPTH = 128;
    localparam int LREG_W           = $clog2(DEF_LOG_RF_DEPTH);
    localparam int PREG_W           = $clog2(DEF_PHY_RF_DEPTH);
    localparam int DEF_FL_DEPTH     = DEF_PHY_RF_DEPTH - DEF_LOG_RF_DEPTH;

    typedef logic [LREG_W-1:0] lreg_t;
    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PREG_W:0]   fcount_t;

    typedef struct packed {
        logic  rd_valid;
        logic  rs1_valid;
        logic  rs2_valid;
        preg_t rd;
        preg_t rs1;
        preg_t rs2;
    } uop_ic_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [15:0] imm;
        uop_ic_t     uop_ic;
    } uop_t;

endpackage

// File: rtl/rename_stage_if.sv
// Decode/dispatch/commit bundle of the rename stage; the stage uses the slave view.
interface rename_stage_if;
    import rename_stage_pkg::*;

    logic    flush;
    logic    in_valid;
    logic    in_ready;
    uop_t    uop_in;
    logic    out_valid;
    logic    out_ready;
    uop_t    uop_out;
    preg_t   old_prd_out;
    logic    commit_valid;
    lreg_t   commit_rd;
    preg_t   commit_prd;
    preg_t   commit_old_prd;
    logic    busy_table_wr_en;
    preg_t   busy_table_wr_addr;
    logic    busy_table_data_out;
    fcount_t free_count;

    modport master (
        output flush, in_valid, uop_in, out_ready,
               commit_valid, commit_rd, commit_prd, commit_old_prd,
        input  in_ready, out_valid, uop_out, old_prd_out,
               busy_table_wr_en, busy_table_wr_addr, busy_table_data_out, free_count
    );

    modport slave (
        input  flush, in_valid, uop_in, out_ready,
               commit_valid, commit_rd, commit_prd, commit_old_prd,
        output in_ready, out_valid, uop_out, old_prd_out,
               busy_table_wr_en, busy_table_wr_addr, busy_table_data_out, free_count
    );

endinterface

// File: rtl/rename_free_list.sv
// Circular free list of physical registers with a speculative head and a committed head
// that flush restores to.
module rename_free_list
    import rename_stage_pkg::*;
#(
    parameter int LOG_RF_DEPTH = DEF_LOG_RF_DEPTH,
    parameter int PHY_RF_DEPTH = DEF_PHY_RF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pop,
    output preg_t                         pop_data,
    input  logic                          push,
    input  preg_t                         push_data,
    input  logic                          commit_adv,
    input  logic                          restore,
    output logic [$clog2(PHY_RF_DEPTH):0] count
);

    localparam int FL_DEPTH = PHY_RF_DEPTH - LOG_RF_DEPTH;
    localparam int PTR_W    = $clog2(FL_DEPTH) + 1;
    localparam int IDX_W    = PTR_W - 1;
    localparam int CNT_W    = $clog2(PHY_RF_DEPTH) + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // FL_DEPTH need not be a power of two, so wrap explicitly
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(FL_DEPTH - 1)) ? {PTR_W{1'b0}} : p + ptr_t'(1);
    endfunction

    preg_t            mem_q [FL_DEPTH];
    preg_t            mem_d [FL_DEPTH];
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    ptr_t             chead_q, chead_d;
    logic [CNT_W-1:0] count_q, count_d;

    // next-state: push at tail, pop at head, restore rewinds head to the committed head
    always_comb begin
        for (int i = 0; i < FL_DEPTH; i++) begin
            mem_d[i] = (push && (tail_q == ptr_t'(i))) ? push_data : mem_q[i];
        end
        tail_d  = push ? ptr_inc(tail_q) : tail_q;
        chead_d = commit_adv ? ptr_inc(chead_q) : chead_q;
        head_d  = restore ? chead_d : (pop ? ptr_inc(head_q) : head_q);
        count_d = restore ? CNT_W'(FL_DEPTH)
                          : count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // state registers; reset loads p[LOG_RF_DEPTH..PHY_RF_DEPTH-1] in order
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= preg_t'(LOG_RF_DEPTH + i);
            end
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            chead_q <= {PTR_W{1'b0}};
            count_q <= CNT_W'(FL_DEPTH);
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            chead_q <= chead_d;
            count_q <= count_d;
        end
    end

    assign pop_data = mem_q[head_q[IDX_W-1:0]];
    assign count    = count_q;

    rename_free_list_chk #(
        .FL_DEPTH (FL_DEPTH),
        .CNT_W    (CNT_W)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .count (count_q)
    );

endmodule

// File: rtl/rename_free_list_chk.sv
// Protocol checker for the free list: a push must never land on a full list.
module rename_free_list_chk #(
    parameter int FL_DEPTH = 96,
    parameter int CNT_W    = 8
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic [CNT_W-1:0] count
);

    // a full list has no in-flight allocation that could legally be retired
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CNT_W'(FL_DEPTH))));

endmodule

// File: rtl/rename_stage.sv
// Register-rename stage: speculative and committed map tables, free list, one-deep output register.
module rename_stage
    import rename_stage_pkg::*;
#(
    parameter int LOG_RF_DEPTH = DEF_LOG_RF_DEPTH,
    parameter int PHY_RF_DEPTH = DEF_PHY_RF_DEPTH
) (
    input logic           clk,
    input logic           rst,
    rename_stage_if.slave io
);

    localparam int LA = $clog2(LOG_RF_DEPTH);
    localparam int PA = $clog2(PHY_RF_DEPTH);

    lreg_t   rd_l_s, rs1_l_s, rs2_l_s;
    logic    needs_alloc_s, in_ready_s, accept_s, pop_s, commit_do_s;
    preg_t   new_prd_s;
    logic [PA:0] fl_count_s;
    uop_t    uop_mapped_s;
    preg_t   old_prd_mapped_s;

    preg_t   spec_map_q   [LOG_RF_DEPTH];
    preg_t   spec_map_d   [LOG_RF_DEPTH];
    preg_t   commit_map_q [LOG_RF_DEPTH];
    preg_t   commit_map_d [LOG_RF_DEPTH];
    logic    out_valid_q, out_valid_d;
    uop_t    uop_out_q, uop_out_d;
    preg_t   old_prd_q, old_prd_d;

    // handshake decode; in_ready uses the registered free count only
    always_comb begin
        rd_l_s        = io.uop_in.uop_ic.rd[LA-1:0];
        rs1_l_s       = io.uop_in.uop_ic.rs1[LA-1:0];
        rs2_l_s       = io.uop_in.uop_ic.rs2[LA-1:0];
        needs_alloc_s = io.uop_in.uop_ic.rd_valid && (rd_l_s != {LA{1'b0}});
        in_ready_s    = !io.flush && (!out_valid_q || io.out_ready) &&
                        ((fl_count_s != {(PA+1){1'b0}}) || !needs_alloc_s);
        accept_s      = io.in_valid && in_ready_s;
        pop_s         = accept_s && needs_alloc_s;
        commit_do_s   = io.commit_valid && (io.commit_rd != {LA{1'b0}});
    end

    // sources read the map before this uop's own rd update
    always_comb begin
        uop_mapped_s            = io.uop_in;
        uop_mapped_s.uop_ic.rs1 = io.uop_in.uop_ic.rs1_valid ? spec_map_q[rs1_l_s] : {PA{1'b0}};
        uop_mapped_s.uop_ic.rs2 = io.uop_in.uop_ic.rs2_valid ? spec_map_q[rs2_l_s] : {PA{1'b0}};
        uop_mapped_s.uop_ic.rd  = needs_alloc_s ? new_prd_s : {PA{1'b0}};
        old_prd_mapped_s        = needs_alloc_s ? spec_map_q[rd_l_s] : {PA{1'b0}};
    end

    // map tables; flush copies the committed map including this cycle's commit
    always_comb begin
        for (int i = 0; i < LOG_RF_DEPTH; i++) begin
            commit_map_d[i] = (commit_do_s && (io.commit_rd == lreg_t'(i))) ?
                              io.commit_prd : commit_map_q[i];
        end
        for (int i = 0; i < LOG_RF_DEPTH; i++) begin
            spec_map_d[i] = io.flush ? commit_map_d[i] :
                            ((pop_s && (rd_l_s == lreg_t'(i))) ? new_prd_s : spec_map_q[i]);
        end
    end

    // output register: load on accept, hold until dispatch takes it
    always_comb begin
        out_valid_d = io.flush ? 1'b0 :
                      (accept_s ? 1'b1 : (io.out_ready ? 1'b0 : out_valid_q));
        uop_out_d   = accept_s ? uop_mapped_s : uop_out_q;
        old_prd_d   = accept_s ? old_prd_mapped_s : old_prd_q;
    end

    // state registers; identity map on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LOG_RF_DEPTH; i++) begin
                spec_map_q[i]   <= preg_t'(i);
                commit_map_q[i] <= preg_t'(i);
            end
            out_valid_q <= 1'b0;
            uop_out_q   <= '0;
            old_prd_q   <= {PA{1'b0}};
        end else begin
            spec_map_q   <= spec_map_d;
            commit_map_q <= commit_map_d;
            out_valid_q  <= out_valid_d;
            uop_out_q    <= uop_out_d;
            old_prd_q    <= old_prd_d;
        end
    end

    rename_free_list #(
        .LOG_RF_DEPTH (LOG_RF_DEPTH),
        .PHY_RF_DEPTH (PHY_RF_DEPTH)
    ) u_free_list (
        .clk        (clk),
        .rst        (rst),
        .pop        (pop_s),
        .pop_data   (new_prd_s),
        .push       (commit_do_s),
        .push_data  (io.commit_old_prd),
        .commit_adv (commit_do_s),
        .restore    (io.flush),
        .count      (fl_count_s)
    );

    assign io.in_ready            = in_ready_s;
    assign io.out_valid           = out_valid_q;
    assign io.uop_out             = uop_out_q;
    assign io.old_prd_out         = old_prd_q;
    assign io.busy_table_wr_en    = pop_s;
    assign io.busy_table_wr_addr  = pop_s ? new_prd_s : {PA{1'b0}};
    assign io.busy_table_data_out = 1'b1;
    assign io.free_count          = fl_count_s;

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: vector table plus exhaustion, flush, backpressure and reset sequences.
module tb_rename_stage;
    import rename_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rename_stage_if u_if ();

    rename_stage dut (
        .clk (clk),
        .rst (rst),
        .io  (u_if.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rdv;
        logic [4:0] rd;
        logic       s1v;
        logic [4:0] s1;
        logic       s2v;
        logic [4:0] s2;
        logic [6:0] e_rd;
        logic [6:0] e_s1;
        logic [6:0] e_s2;
        logic [6:0] e_old;
        logic       e_busy;
        logic [7:0] e_fc;
    } vec_t;

    localparam int NV = 6;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_uop(input logic rdv, input logic [4:0] rd, input logic s1v,
                           input logic [4:0] s1, input logic s2v, input logic [4:0] s2,
                           input logic [15:0] imm);
        uop_t u;
        u                  = '0;
        u.opcode           = 7'h33;
        u.imm              = imm;
        u.uop_ic.rd_valid  = rdv;
        u.uop_ic.rs1_valid = s1v;
        u.uop_ic.rs2_valid = s2v;
        u.uop_ic.rd        = {2'b00, rd};
        u.uop_ic.rs1       = {2'b00, s1};
        u.uop_ic.rs2       = {2'b00, s2};
        u_if.uop_in        = u;
    endtask

    task automatic idle_inputs();
        u_if.flush          = 1'b0;
        u_if.in_valid       = 1'b0;
        u_if.out_ready      = 1'b1;
        u_if.commit_valid   = 1'b0;
        u_if.commit_rd      = 5'd0;
        u_if.commit_prd     = 7'd0;
        u_if.commit_old_prd = 7'd0;
        set_uop(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 16'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 7'd32, 7'd1,  7'd2,  7'd5,  1'b1, 8'd95};
        vt[1] = '{1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd9, 7'd33, 7'd3,  7'd0,  7'd3,  1'b1, 8'd94};
        vt[2] = '{1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd5, 7'd34, 7'd33, 7'd32, 7'd33, 1'b1, 8'd93};
        vt[3] = '{1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 5'd3, 7'd0,  7'd32, 7'd34, 7'd0,  1'b0, 8'd93};
        vt[4] = '{1'b0, 5'd7, 1'b1, 5'd0, 1'b1, 5'd7, 7'd0,  7'd0,  7'd7,  7'd0,  1'b0, 8'd93};
        vt[5] = '{1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 7'd35, 7'd32, 7'd0,  7'd32, 1'b1, 8'd92};

        do_reset();
        chk("reset out_valid", 64'(u_if.out_valid), 64'd0);
        chk("reset free_count", 64'(u_if.free_count), 64'd96);
        chk("reset old_prd", 64'(u_if.old_prd_out), 64'd0);
        chk("reset uop_out", 64'(u_if.uop_out), 64'd0);
        chk("reset busy_en", 64'(u_if.busy_table_wr_en), 64'd0);
        chk("reset in_ready", 64'(u_if.in_ready), 64'd1);

        // table: back-to-back uops from reset
        for (int i = 0; i < NV; i++) begin
            set_uop(vt[i].rdv, vt[i].rd, vt[i].s1v, vt[i].s1, vt[i].s2v, vt[i].s2, 16'(i * 7 + 3));
            u_if.in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d in_ready", i), 64'(u_if.in_ready), 64'd1);
            chk($sformatf("v%0d busy_en", i), 64'(u_if.busy_table_wr_en), 64'(vt[i].e_busy));
            if (vt[i].e_busy)
                chk($sformatf("v%0d busy_addr", i), 64'(u_if.busy_table_wr_addr), 64'(vt[i].e_rd));
            step();
            u_if.in_valid = 1'b0;
            chk($sformatf("v%0d out_valid", i), 64'(u_if.out_valid), 64'd1);
            chk($sformatf("v%0d rd", i), 64'(u_if.uop_out.uop_ic.rd), 64'(vt[i].e_rd));
            chk($sformatf("v%0d rs1", i), 64'(u_if.uop_out.uop_ic.rs1), 64'(vt[i].e_s1));
            chk($sformatf("v%0d rs2", i), 64'(u_if.uop_out.uop_ic.rs2), 64'(vt[i].e_s2));
            chk($sformatf("v%0d old_prd", i), 64'(u_if.old_prd_out), 64'(vt[i].e_old));
            chk($sformatf("v%0d imm", i), 64'(u_if.uop_out.imm), 64'(i * 7 + 3));
            chk($sformatf("v%0d free_count", i), 64'(u_if.free_count), 64'(vt[i].e_fc));
        end
        step();
        chk("drain out_valid", 64'(u_if.out_valid), 64'd0);

        // exhaustion: 96 allocations, then a commit frees p5
        do_reset();
        for (int i = 0; i < 96; i++) begin
            set_uop(1'b1, 5'(((i + 4) % 31) + 1), 1'b0, 5'd0, 1'b0, 5'd0, 16'(i));
            u_if.in_valid = 1'b1;
            step();
        end
        chk("exhaust free_count", 64'(u_if.free_count), 64'd0);
        set_uop(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 16'd500);
        u_if.commit_valid   = 1'b1;
        u_if.commit_rd      = 5'd5;
        u_if.commit_prd     = 7'd32;
        u_if.commit_old_prd = 7'd5;
        @(negedge clk);
        chk("empty in_ready", 64'(u_if.in_ready), 64'd0);
        chk("empty busy_en", 64'(u_if.busy_table_wr_en), 64'd0);
        step();
        u_if.commit_valid = 1'b0;
        chk("commit free_count", 64'(u_if.free_count), 64'd1);
        chk("stall out_valid", 64'(u_if.out_valid), 64'd0);
        @(negedge clk);
        chk("refill in_ready", 64'(u_if.in_ready), 64'd1);
        chk("refill busy_addr", 64'(u_if.busy_table_wr_addr), 64'd5);
        step();
        chk("recycled rd", 64'(u_if.uop_out.uop_ic.rd), 64'd5);
        chk("recycled old_prd", 64'(u_if.old_prd_out), 64'd98);
        chk("recycled free_count", 64'(u_if.free_count), 64'd0);
        set_uop(1'b0, 5'd4, 1'b1, 5'd1, 1'b0, 5'd0, 16'd501);
        @(negedge clk);
        chk("empty nonalloc in_ready", 64'(u_if.in_ready), 64'd1);
        step();
        u_if.in_valid = 1'b0;

        // flush after three allocations with the first committing in the same cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_uop(1'b1, 5'(i + 1), 1'b0, 5'd0, 1'b0, 5'd0, 16'd0);
            u_if.in_valid = 1'b1;
            step();
        end
        set_uop(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 16'd0);
        u_if.flush          = 1'b1;
        u_if.commit_valid   = 1'b1;
        u_if.commit_rd      = 5'd1;
        u_if.commit_prd     = 7'd32;
        u_if.commit_old_prd = 7'd1;
        @(negedge clk);
        chk("flush in_ready", 64'(u_if.in_ready), 64'd0);
        chk("flush busy_en", 64'(u_if.busy_table_wr_en), 64'd0);
        step();
        u_if.flush        = 1'b0;
        u_if.commit_valid = 1'b0;
        chk("flush out_valid", 64'(u_if.out_valid), 64'd0);
        chk("flush free_count", 64'(u_if.free_count), 64'd96);
        set_uop(1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd3, 16'd0);
        step();
        chk("post-flush rd", 64'(u_if.uop_out.uop_ic.rd), 64'd33);
        chk("post-flush rs1", 64'(u_if.uop_out.uop_ic.rs1), 64'd32);
        chk("post-flush rs2", 64'(u_if.uop_out.uop_ic.rs2), 64'd3);
        chk("post-flush old_prd", 64'(u_if.old_prd_out), 64'd4);
        set_uop(1'b1, 5'd5, 1'b1, 5'd2, 1'b0, 5'd0, 16'd0);
        step();
        u_if.in_valid = 1'b0;
        chk("post-flush rd2", 64'(u_if.uop_out.uop_ic.rd), 64'd34);
        chk("post-flush rs1 x2", 64'(u_if.uop_out.uop_ic.rs1), 64'd2);
        chk("post-flush free_count", 64'(u_if.free_count), 64'd94);

        // backpressure: output held for four cycles
        do_reset();
        u_if.out_ready = 1'b0;
        set_uop(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 16'd0);
        u_if.in_valid = 1'b1;
        step();
        set_uop(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 16'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d in_ready", k), 64'(u_if.in_ready), 64'd0);
            chk($sformatf("bp%0d busy_en", k), 64'(u_if.busy_table_wr_en), 64'd0);
            step();
            chk($sformatf("bp%0d out_valid", k), 64'(u_if.out_valid), 64'd1);
            chk($sformatf("bp%0d rd", k), 64'(u_if.uop_out.uop_ic.rd), 64'd32);
            chk($sformatf("bp%0d free_count", k), 64'(u_if.free_count), 64'd95);
        end
        u_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", 64'(u_if.in_ready), 64'd1);
        step();
        u_if.in_valid = 1'b0;
        chk("bp release rd", 64'(u_if.uop_out.uop_ic.rd), 64'd33);
        chk("bp release old_prd", 64'(u_if.old_prd_out), 64'd7);
        chk("bp release free_count", 64'(u_if.free_count), 64'd94);

        // reset overrides a concurrent accept and flush
        set_uop(1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 16'd0);
        u_if.in_valid = 1'b1;
        u_if.flush    = 1'b1;
        rst           = 1'b1;
        step();
        rst        = 1'b0;
        u_if.flush = 1'b0;
        chk("rst-mid free_count", 64'(u_if.free_count), 64'd96);
        chk("rst-mid out_valid", 64'(u_if.out_valid), 64'd0);
        step();
        u_if.in_valid = 1'b0;
        chk("rst-mid rd", 64'(u_if.uop_out.uop_ic.rd), 64'd32);
        chk("rst-mid old_prd", 64'(u_if.old_prd_out), 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
